// File: rtl/sift_grad_pkg.sv
// Shared constants and helpers for the sift gradient stage; the tangent thresholds
// and bin count match the ones sift_desc uses for its main-direction search.
package sift_grad_pkg;

  localparam int PIX_W          = 8;
  localparam int MAG_W          = 8;
  localparam int DIFF_W         = PIX_W + 1;
  localparam int SIFT_DIR_BINS  = 36;
  localparam int SIFT_TAN_SHIFT = 10;
  localparam int TAN_W          = 13;
  localparam int PROD_W         = PIX_W + TAN_W;

  localparam logic [TAN_W-1:0] SIFT_TAN_T1 = 13'd181;
  localparam logic [TAN_W-1:0] SIFT_TAN_T2 = 13'd373;
  localparam logic [TAN_W-1:0] SIFT_TAN_T3 = 13'd591;
  localparam logic [TAN_W-1:0] SIFT_TAN_T4 = 13'd859;
  localparam logic [TAN_W-1:0] SIFT_TAN_T5 = 13'd1220;
  localparam logic [TAN_W-1:0] SIFT_TAN_T6 = 13'd1774;
  localparam logic [TAN_W-1:0] SIFT_TAN_T7 = 13'd2813;
  localparam logic [TAN_W-1:0] SIFT_TAN_T8 = 13'd5807;

  // Each quadrant spans a quarter of the bins: bases 0, 9, 18, 27.
  localparam logic [5:0] QUAD_BINS = 6'(SIFT_DIR_BINS / 4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } grad_state_t;

  function automatic logic [TAN_W-1:0] tan_t(input int i);
    case (i)
      1:       return SIFT_TAN_T1;
      2:       return SIFT_TAN_T2;
      3:       return SIFT_TAN_T3;
      4:       return SIFT_TAN_T4;
      5:       return SIFT_TAN_T5;
      6:       return SIFT_TAN_T6;
      7:       return SIFT_TAN_T7;
      default: return SIFT_TAN_T8;
    endcase
  endfunction

  // Differences of two unsigned pixels never reach -256, so the result fits PIX_W.
  function automatic logic [PIX_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] d);
    logic signed [DIFF_W-1:0] n;
    n = -d;
    return d[DIFF_W-1] ? n[PIX_W-1:0] : d[PIX_W-1:0];
  endfunction

  function automatic logic [MAG_W-1:0] sat_mag(input logic [MAG_W+1:0] s);
    return (|s[MAG_W+1:MAG_W]) ? {MAG_W{1'b1}} : s[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/sift_grad_dir.sv
// Direction quantizer: registers quadrant and (u,v) ordering, then maps the
// ratio v/u onto one of nine bins inside the quadrant with eight comparators.
module sift_grad_dir
  import sift_grad_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DIFF_W-1:0] dx,
  input  logic signed [DIFF_W-1:0] dy,
  output logic [7:0]               dir
);

  logic [PIX_W-1:0] a_n, b_n, u_n, v_n;
  logic [5:0]       base_n;
  logic             zero_n;
  logic             dx_pos, dx_neg, dy_pos, dy_neg;

  logic [PIX_W-1:0] s2_u, s2_v;
  logic [5:0]       s2_base;
  logic             s2_zero;
  logic [3:0]       k;

  always_comb begin
    a_n    = abs_diff(dx);
    b_n    = abs_diff(dy);
    dx_neg = dx[DIFF_W-1];
    dy_neg = dy[DIFF_W-1];
    dx_pos = !dx_neg && (|dx);
    dy_pos = !dy_neg && (|dy);
    zero_n = !(|dx) && !(|dy);
    base_n = 6'(3) * QUAD_BINS;
    u_n    = b_n;
    v_n    = a_n;
    if (dx_pos && !dy_neg) begin
      base_n = '0;
      u_n    = a_n;
      v_n    = b_n;
    end else if (!dx_pos && dy_pos) begin
      base_n = QUAD_BINS;
    end else if (dx_neg && !dy_pos) begin
      base_n = 6'(2) * QUAD_BINS;
      u_n    = a_n;
      v_n    = b_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_u    <= '0;
      s2_v    <= '0;
      s2_base <= '0;
      s2_zero <= 1'b0;
    end else begin
      s2_u    <= u_n;
      s2_v    <= v_n;
      s2_base <= base_n;
      s2_zero <= zero_n;
    end
  end

  // k counts thresholds passed by v/u, evaluated as v*2^SHIFT >= u*T[i].
  always_comb begin
    k = '0;
    for (int i = 1; i <= 8; i++) begin
      if (PROD_W'({s2_v, {SIFT_TAN_SHIFT{1'b0}}}) >= PROD_W'(s2_u) * PROD_W'(tan_t(i)))
        k = k + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir <= '0;
    else     dir <= s2_zero ? 8'd0 : {2'b00, s2_base + {2'b00, k}};
  end

endmodule

// File: rtl/sift_grad.sv
// Gradient stage feeding sift_desc: line-buffered 3x3 window, 3-cycle pipeline
// to magnitude/direction. Define SIFT_GRAD_L1_EN for the |dx|+|dy| magnitude.
module sift_grad
  import sift_grad_pkg::*;
#(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_in,
  output logic              grad_valid,
  output logic [ADDR_W-1:0] addr_out,
  output logic [MAG_W-1:0]  mag_out,
  output logic [7:0]        dir_out,
  output logic              frame_done,
  output logic              busy
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  // Pixel handshake: a pixel is taken on any cycle with pix_valid high while the
  // FSM is RUN, or with pix_valid & sof in IDLE/RUN; there is no backpressure.
  grad_state_t state, state_n;

  logic [XW-1:0] x_cnt, px;
  logic [YW-1:0] y_cnt, py;
  logic          restart, accept, launch, last_pix;

  always_comb begin
    restart  = pix_valid && sof && (state != ST_DONE);
    accept   = restart || (pix_valid && (state == ST_RUN));
    px       = restart ? '0 : x_cnt;
    py       = restart ? '0 : y_cnt;
    launch   = accept && (px >= XW'(2)) && (py >= YW'(2));
    last_pix = accept && (px == X_LAST) && (py == Y_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (px == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= py + 1'b1;
      end else begin
        x_cnt <= px + 1'b1;
        y_cnt <= py;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (restart)    state_n = ST_RUN;
      ST_RUN:  if (last_pix)   state_n = ST_DONE;
      ST_DONE: if (frame_done) state_n = ST_IDLE;
      default:                 state_n = ST_IDLE;
    endcase
  end

  // lb0 holds row y-1, lb1 row y-2; both are read at the incoming column.
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] up1, up2;

  assign up1 = lb0[px];
  assign up2 = lb1[px];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[px] <= up1;
      lb0[px] <= pix_in;
    end
  end

  // Only the window taps the gradient needs: middle row at x-1/x-2, top/bottom at x-1.
  logic [PIX_W-1:0] mid_c1, mid_c2, top_c1, bot_c1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mid_c1 <= '0;
      mid_c2 <= '0;
      top_c1 <= '0;
      bot_c1 <= '0;
    end else if (accept) begin
      mid_c2 <= mid_c1;
      mid_c1 <= up1;
      top_c1 <= up2;
      bot_c1 <= pix_in;
    end
  end

  logic signed [DIFF_W-1:0] dx_n, dy_n;
  logic [ADDR_W-1:0]        addr_n;

  always_comb begin
    dx_n   = $signed({1'b0, up1}) - $signed({1'b0, mid_c2});
    dy_n   = $signed({1'b0, bot_c1}) - $signed({1'b0, top_c1});
    addr_n = ADDR_W'(py - 1'b1) * ADDR_W'(IMG_W) + ADDR_W'(px - 1'b1);
  end

  logic                     s1_v, s1_last;
  logic signed [DIFF_W-1:0] s1_dx, s1_dy;
  logic [ADDR_W-1:0]        s1_addr;
  logic                     s2_v, s2_last, s3_last;
  logic [MAG_W-1:0]         s2_mag;
  logic [ADDR_W-1:0]        s2_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_dx   <= '0;
      s1_dy   <= '0;
      s1_addr <= '0;
    end else begin
      s1_v    <= launch;
      s1_last <= last_pix;
      s1_dx   <= dx_n;
      s1_dy   <= dy_n;
      s1_addr <= addr_n;
    end
  end

  logic [PIX_W-1:0] mag_a, mag_b;
  logic [MAG_W+1:0] mag_sum;

  always_comb begin
    mag_a = abs_diff(s1_dx);
    mag_b = abs_diff(s1_dy);
`ifdef SIFT_GRAD_L1_EN
    mag_sum = {2'b00, mag_a} + {2'b00, mag_b};
`else
    if (mag_a >= mag_b) mag_sum = {2'b00, mag_a} + {3'b000, mag_b[PIX_W-1:1]};
    else                mag_sum = {2'b00, mag_b} + {3'b000, mag_a[PIX_W-1:1]};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v       <= 1'b0;
      s2_last    <= 1'b0;
      s2_mag     <= '0;
      s2_addr    <= '0;
      grad_valid <= 1'b0;
      s3_last    <= 1'b0;
      mag_out    <= '0;
      addr_out   <= '0;
    end else begin
      s2_v       <= s1_v;
      s2_last    <= s1_v && s1_last;
      s2_mag     <= sat_mag(mag_sum);
      s2_addr    <= s1_addr;
      grad_valid <= s2_v;
      s3_last    <= s2_v && s2_last;
      mag_out    <= s2_mag;
      addr_out   <= s2_addr;
    end
  end

  sift_grad_dir u_dir (
    .clk (clk),
    .rst (rst),
    .dx  (s1_dx),
    .dy  (s1_dy),
    .dir (dir_out)
  );

  always_comb begin
    busy       = (state != ST_IDLE);
    frame_done = grad_valid && s3_last;
  end

endmodule

// File: tb/tb_sift_grad.sv
// Directed bench for sift_grad on an 8x6 frame: scoreboard of expected writes,
// per-result latency tracking, frame_done/busy checks, reset and restart cases.
module tb_sift_grad;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 18;
  localparam int EW = AW + 8 + 8 + 1;

  logic          clk, rst, sof, pix_valid;
  logic [7:0]    pix_in;
  logic          grad_valid, frame_done, busy;
  logic [AW-1:0] addr_out;
  logic [7:0]    mag_out, dir_out;

  sift_grad #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sof        (sof),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .grad_valid (grad_valid),
    .addr_out   (addr_out),
    .mag_out    (mag_out),
    .dir_out    (dir_out),
    .frame_done (frame_done),
    .busy       (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  int            n_wr   = 0;
  int            n_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // expected-value tables
  function automatic logic [7:0] pix_of(input int pat, input int x, input int y);
    case (pat)
      0:       return 8'd77;
      1:       return 8'(10 * x);
      2:       return 8'(255 - 10 * x);
      3:       return 8'(10 * y);
      4:       return 8'(250 - 10 * y);
      5:       return 8'(10 * (x + y));
      default: return (x >= 4) ? 8'd255 : 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] exp_mag(input int pat, input int cx);
    case (pat)
      0:       return 8'd0;
      1, 2, 3, 4: return 8'd20;
`ifdef SIFT_GRAD_L1_EN
      5:       return 8'd40;
`else
      5:       return 8'd30;
`endif
      default: return (cx == 3 || cx == 4) ? 8'd255 : 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] exp_dir(input int pat);
    case (pat)
      2:       return 8'd18;
      3:       return 8'd9;
      4:       return 8'd27;
      5:       return 8'd4;
      default: return 8'd0;
    endcase
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            l;
    if (frame_done) n_done++;
    if (grad_valid) begin
      n_wr++;
      chk("q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("addr", addr_out, e[EW-1:17]);
        chk("mag", mag_out, e[16:9]);
        chk("dir", dir_out, e[8:1]);
        chk("frame_done", frame_done, e[0]);
      end
      if (lat_q.size() != 0) begin
        l = lat_q.pop_front();
        chk("latency", cyc - l, 3);
      end
    end
  end

  // drivers
  task automatic put(input logic s, input logic [7:0] p);
    @(posedge clk); #1;
    sof       = s;
    pix_valid = 1'b1;
    pix_in    = p;
  endtask

  task automatic idle_cyc();
    @(posedge clk); #1;
    sof       = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    sof       = 1'b0;
    pix_valid = 1'b0;
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    n_wr   = 0;
    n_done = 0;
  endtask

  // Sends a frame in raster order; stop_at >= 0 abandons it before that pixel index.
  task automatic run_frame(input int pat, input int gap_pct, input int stop_at);
    logic [EW-1:0] e;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y * W + x == stop_at) return;
        if (gap_pct > 0) begin
          for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) idle_cyc();
        end
        put(x == 0 && y == 0, pix_of(pat, x, y));
        if (x >= 2 && y >= 2) begin
          e = {AW'((y - 1) * W + (x - 1)), exp_mag(pat, x - 1), exp_dir(pat),
               (x == W - 1 && y == H - 1)};
          exp_q.push_back(e);
          lat_q.push_back(cyc);
        end
      end
    end
    idle_cyc();
  endtask

  task automatic finish_frame(input int exp_wr);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    chk("writes", n_wr, exp_wr);
    chk("done_cnt", n_done, 1);
    chk("busy_idle", busy, 0);
    n_wr   = 0;
    n_done = 0;
  endtask

  initial begin
    rst       = 1'b1;
    sof       = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grad_valid", grad_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_mag", mag_out, 0);
    chk("rst_dir", dir_out, 0);
    rst = 1'b0;

    // pixels without sof in IDLE are dropped
    put(1'b0, 8'd5);
    put(1'b0, 8'd6);
    put(1'b0, 8'd7);
    idle_cyc();
    repeat (5) @(posedge clk);
    #1;
    chk("stray_busy", busy, 0);
    chk("stray_writes", n_wr, 0);

    // uniform, ramps, diagonal, step
    for (int p = 0; p <= 6; p++) begin
      run_frame(p, 0, -1);
      finish_frame(24);
    end

    // diagonal with random input gaps
    run_frame(5, 50, -1);
    finish_frame(24);

    // reset in the middle of a frame, then a clean frame
    run_frame(1, 0, 30);
    do_reset();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", grad_valid, 0);
    run_frame(3, 0, -1);
    finish_frame(24);

    // sof at pixel 20 restarts; the two launched centres drain, then 24 new writes
    run_frame(5, 0, 20);
    chk("restart_busy", busy, 1);
    run_frame(5, 0, -1);
    finish_frame(26);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
